// File: rtl/cache_fifo_pkg.sv
// ============================================================================
// Module      : cache_fifo_pkg
// Description : Shared types, default widths and helpers for the cache FIFO
//               and its read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TAG_WIDTH  = 8;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_fifo_rd_arbiter_rr.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker; search starts at i_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import cache_fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_winner,
    output logic               o_valid
);

    int w_idx;

    always_comb begin
        o_grant  = '0;
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQ;
            if (i_en && !o_valid && i_req[w_idx]) begin
                o_valid         = 1'b1;
                o_grant[w_idx]  = 1'b1;
                o_winner        = IW'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_fifo_rd_arbiter.sv
// ============================================================================
// Module      : cache_fifo_rd_arbiter
// Description : Round-robin sharing of the cache FIFO read port, one tagged
//               read outstanding, with timeout-protected responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_fifo_rd_arbiter
    import cache_fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int TIMEOUT    = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           rsp_hit,
    output logic                           rsp_err,
    input  logic                           cf_empty,
    output logic                           cf_rd_en,
    output logic [TAG_WIDTH-1:0]           cf_rd_tag,
    input  logic                           cf_rd_valid,
    input  logic [DATA_WIDTH-1:0]          cf_rd_data,
    input  logic                           cf_rd_hit,
    output logic                           busy,
    output logic [clog2_min1(NUM_REQ)-1:0] grant_id
);

    localparam int IW = clog2_min1(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_RESP  = RESP;

    logic [1:0]            r_state;
    logic [IW-1:0]         r_rr_ptr;
    logic [IW-1:0]         r_grant_id;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_hit;
    logic                  r_rsp_err;
    logic [TW-1:0]         r_timer;

    logic [NUM_REQ-1:0]    w_grant;
    logic [IW-1:0]         w_winner;
    logic                  w_gnt_valid;
    logic                  w_arb_en;
    logic [NUM_REQ-1:0]    w_rsp_valid;

    assign w_arb_en = (r_state == ST_IDLE) && !cf_empty;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_arbiter (
        .i_req    (req_valid),
        .i_ptr    (r_rr_ptr),
        .i_en     (w_arb_en),
        .o_grant  (w_grant),
        .o_winner (w_winner),
        .o_valid  (w_gnt_valid)
    );

    always_comb begin
        w_rsp_valid = '0;
        if (r_state == ST_RESP) begin
            w_rsp_valid[r_grant_id] = 1'b1;
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = w_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_err   = r_rsp_err;
    assign cf_rd_en  = (r_state == ST_ISSUE);
    assign cf_rd_tag = r_tag;
    assign busy      = (r_state != ST_IDLE);
    assign grant_id  = r_grant_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_tag      <= '0;
            r_rsp_data <= '0;
            r_rsp_hit  <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_timer    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_tag      <= req_tag[w_winner*TAG_WIDTH +: TAG_WIDTH];
                        r_grant_id <= w_winner;
                        r_rr_ptr   <= (w_winner == IW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Returned data takes priority over a coincident timeout.
                    if (cf_rd_valid) begin
                        r_rsp_data <= cf_rd_data;
                        r_rsp_hit  <= cf_rd_hit;
                        r_rsp_err  <= 1'b0;
                        r_state    <= ST_RESP;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        r_rsp_data <= '0;
                        r_rsp_hit  <= 1'b0;
                        r_rsp_err  <= 1'b1;
                        r_state    <= ST_RESP;
                    end else if (r_timer != {TW{1'b1}}) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[r_grant_id]) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_fifo_rd_arbiter.sv
// ============================================================================
// Module      : tb_cache_fifo_rd_arbiter
// Description : Self-checking bench: transaction-level model plus directed tests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_fifo_rd_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] req_tag;
    logic [31:0] rsp_data, cf_rd_data;
    logic        rsp_hit, rsp_err, cf_empty, cf_rd_en, cf_rd_valid, cf_rd_hit, busy;
    logic [7:0]  cf_rd_tag;
    logic [1:0]  grant_id;

    int n_checks = 0;
    int n_err    = 0;

    // model: phase 0 idle, 1 read issued, 2 awaiting data, 3 response held
    int          m_phase, m_ptr, m_gid, m_wcnt;
    logic [7:0]  m_tag;
    logic [31:0] m_data;
    logic        m_hit, m_err;

    bit   cf_auto = 1'b0;
    logic en_prev;

    cache_fifo_rd_arbiter #(
        .NUM_REQ(NREQ), .DATA_WIDTH(32), .TAG_WIDTH(8), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_hit(rsp_hit), .rsp_err(rsp_err),
        .cf_empty(cf_empty), .cf_rd_en(cf_rd_en), .cf_rd_tag(cf_rd_tag),
        .cf_rd_valid(cf_rd_valid), .cf_rd_data(cf_rd_data), .cf_rd_hit(cf_rd_hit),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] exp_rr;
        int w;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_hit", rsp_hit, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_cf_rd_en", cf_rd_en, 0);
            chk("rst_cf_rd_tag", cf_rd_tag, 0);
            chk("rst_busy", busy, 0);
            chk("rst_grant_id", grant_id, 0);
            m_phase = 0; m_ptr = 0; m_gid = 0; m_wcnt = 0;
            m_tag = '0; m_data = '0; m_hit = 1'b0; m_err = 1'b0;
            return;
        end
        exp_rr = '0;
        w = -1;
        if (m_phase == 0 && !cf_empty) begin
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            if (w >= 0) exp_rr[w] = 1'b1;
        end
        chk("req_ready", req_ready, exp_rr);
        chk("busy", busy, (m_phase != 0) ? 1 : 0);
        chk("grant_id", grant_id, m_gid);
        chk("cf_rd_tag", cf_rd_tag, m_tag);
        chk("cf_rd_en", cf_rd_en, (m_phase == 1) ? 1 : 0);
        chk("rsp_valid", rsp_valid, (m_phase == 3) ? (64'd1 << m_gid) : 0);
        if (m_phase == 3) begin
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_hit", rsp_hit, m_hit);
            chk("rsp_err", rsp_err, m_err);
        end
        case (m_phase)
            0: if (w >= 0) begin
                m_gid = w; m_tag = req_tag[w*8 +: 8]; m_ptr = (w + 1) % NREQ; m_phase = 1;
            end
            1: begin m_phase = 2; m_wcnt = 0; end
            2: begin
                if (cf_rd_valid) begin
                    m_data = cf_rd_data; m_hit = cf_rd_hit; m_err = 1'b0; m_phase = 3;
                end else begin
                    m_wcnt++;
                    if (m_wcnt == TMO) begin
                        m_data = '0; m_hit = 1'b0; m_err = 1'b1; m_phase = 3;
                    end
                end
            end
            default: if (rsp_ready[m_gid]) m_phase = 0;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int idx, output int n);
        bit seen;
        seen = 1'b0; idx = -1; n = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (|req_ready) begin
                seen = 1'b1;
                for (int j = 0; j < NREQ; j++) if (req_ready[j]) idx = j;
            end
        end
        chk("grant_seen", seen, 1);
    endtask

    task automatic wait_rsp(output int n);
        bit seen;
        seen = 1'b0; n = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (|rsp_valid) seen = 1'b1;
        end
        chk("rsp_seen", seen, 1);
    endtask

    initial begin
        int idx, n;
        logic [31:0] d;
        rst_n = 1'b1; req_valid = '0; req_tag = '0; rsp_ready = '0; cf_empty = 1'b0;
        cf_rd_valid = 1'b0; cf_rd_data = '0; cf_rd_hit = 1'b0;
        fork
            forever begin
                @(negedge clk);
                model_step();
            end
            forever begin
                @(negedge clk);
                en_prev = cf_rd_en;
                @(posedge clk);
                #1;
                if (cf_auto) begin
                    cf_rd_valid = en_prev;
                    if (en_prev) begin
                        cf_rd_data = $urandom;
                        cf_rd_hit  = 1'($urandom_range(0, 1));
                    end
                end
            end
        join_none
        #2 rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;

        // single request with hand-computed response
        req_valid = 4'b0001; req_tag = 32'h0000_003C;
        wait_grant(idx, n);
        chk("t1_grant", idx, 0);
        step(); req_valid = '0;
        @(negedge clk);
        chk("t1_rd_en", cf_rd_en, 1);
        chk("t1_rd_tag", cf_rd_tag, 8'h3C);
        step(); cf_rd_valid = 1'b1; cf_rd_data = 32'hDEADBEEF; cf_rd_hit = 1'b1;
        step(); cf_rd_valid = 1'b0;
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_rsp_data", rsp_data, 32'hDEADBEEF);
        chk("t1_rsp_hit", rsp_hit, 1);
        chk("t1_rsp_err", rsp_err, 0);
        step(); rsp_ready = 4'b0001;
        step(); rsp_ready = '0;

        // round-robin fairness from a fresh pointer
        rst_n = 1'b0;
        step(); rst_n = 1'b1;
        req_valid = 4'b1111; rsp_ready = 4'b1111; cf_auto = 1'b1;
        req_tag = 32'hA3A2A1A0;
        for (int k = 0; k < 8; k++) begin
            wait_grant(idx, n);
            chk("t2_rr_order", idx, k % 4);
            if (k > 0) chk("t2_turnaround", n, 4);
        end
        step(); req_valid = '0;
        repeat (6) step();

        // empty gating
        cf_empty = 1'b1; req_valid = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_no_grant", req_ready, 0);
            chk("t3_no_rd_en", cf_rd_en, 0);
        end
        step(); cf_empty = 1'b0;
        @(negedge clk);
        chk("t3_grant_after_empty", req_ready, 4'b0010);
        step(); req_valid = '0;
        repeat (6) step();

        // timeout
        cf_auto = 1'b0; cf_rd_valid = 1'b0; rsp_ready = '0; req_valid = 4'b0001;
        wait_grant(idx, n);
        chk("t4_grant", idx, 0);
        step(); req_valid = '0;
        wait_rsp(n);
        chk("t4_timeout_latency", n, TMO + 2);
        chk("t4_err", rsp_err, 1);
        chk("t4_data", rsp_data, 0);
        chk("t4_hit", rsp_hit, 0);
        step(); rsp_ready = 4'b0001;
        step(); rsp_ready = '0; cf_rd_valid = 1'b1; cf_rd_data = 32'h12345678; cf_rd_hit = 1'b1;
        @(negedge clk);
        chk("t4_stale_busy", busy, 0);
        step();
        @(negedge clk);
        chk("t4_stale_rsp", rsp_valid, 0);
        chk("t4_stale_busy2", busy, 0);
        step(); cf_rd_valid = 1'b0;

        // response backpressure on requester 2
        cf_auto = 1'b1; rsp_ready = 4'b1011; req_valid = 4'b0100;
        wait_grant(idx, n);
        chk("t5_grant2", idx, 2);
        step(); req_valid = 4'b1011;
        wait_rsp(n);
        d = rsp_data;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t5_rsp_valid", rsp_valid, 4'b0100);
            chk("t5_data_stable", rsp_data, d);
            chk("t5_no_grant", req_ready, 0);
            chk("t5_busy", busy, 1);
        end
        step(); rsp_ready = 4'b1111;
        wait_grant(idx, n);
        chk("t5_next_grant", idx, 3);
        step(); req_valid = '0;
        repeat (6) step();

        // reset during WAIT
        cf_auto = 1'b0; cf_rd_valid = 1'b0; req_valid = 4'b0001;
        wait_grant(idx, n);
        chk("t6_grant", idx, 0);
        step(); req_valid = '0;
        step(); rst_n = 1'b0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_rd_en", cf_rd_en, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        step(); rst_n = 1'b1; cf_rd_valid = 1'b1; cf_rd_data = 32'hBAD0BAD0;
        @(negedge clk);
        chk("t6_stale_rsp", rsp_valid, 0);
        chk("t6_stale_busy", busy, 0);
        step(); cf_rd_valid = 1'b0; req_valid = 4'b1111; cf_auto = 1'b1;
        wait_grant(idx, n);
        chk("t6_grant_after_rst", idx, 0);
        step(); req_valid = '0;
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cache_fifo_rd_arbiter.md
Name: cache_fifo_rd_arbiter

Overview:
Shares the single read port of the tagged cache FIFO among NUM_REQ requesters. Uses round-robin arbitration and issues one tagged read at a time. It captures the data and hit flag returned by the cache FIFO and routes them to the winning requester through a valid/ready response handshake. A timeout guards against a missing rd_valid. Sits between client read engines and the cache FIFO's rd_en/rd_tag/rd_data/rd_valid/rd_hit interface.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 32, read data width; must match the cache FIFO
TAG_WIDTH, 8, tag width; must match the cache FIFO
TIMEOUT, 15, max cycles spent in WAIT before an error response (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester read request
req_tag  in  NUM_REQ*TAG_WIDTH  per-requester tag; requester i uses slice [i*TAG_WIDTH +: TAG_WIDTH]
req_ready  out  NUM_REQ  one-hot grant pulse; the request is accepted when valid&ready
rsp_valid  out  NUM_REQ  one-hot response valid; held until accepted
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_data  out  DATA_WIDTH  response data, shared by all requesters
rsp_hit  out  1  cache hit flag for the response
rsp_err  out  1  timeout error flag for the response
cf_empty  in  1  cache FIFO empty
cf_rd_en  out  1  cache FIFO read strobe
cf_rd_tag  out  TAG_WIDTH  cache FIFO read tag
cf_rd_valid  in  1  cache FIFO read valid; arrives one cycle after cf_rd_en
cf_rd_data  in  DATA_WIDTH  cache FIFO read data
cf_rd_hit  in  1  cache FIFO hit flag
busy  out  1  high whenever state != IDLE
grant_id  out  $clog2(NUM_REQ)  index of the current or most recent winner

Behaviour:
- Reset values: state=IDLE; rr_ptr=0; all outputs 0. This includes req_ready, rsp_valid, rsp_data, rsp_hit, rsp_err, cf_rd_en, cf_rd_tag, busy and grant_id.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid and !cf_empty: pick the winner by round-robin, starting the search at rr_ptr.
  - Pulse req_ready[winner] combinationally in that cycle.
  - Register the winner's tag into cf_rd_tag and set grant_id=winner.
  - Set rr_ptr=(winner+1) mod NUM_REQ, then go to ISSUE.
  - If cf_empty=1: no grant is made and req_ready stays 0.
- ISSUE: cf_rd_en=1 for exactly one cycle; the timer is cleared; go to WAIT.
- WAIT:
  - If cf_rd_valid=1: register rsp_data=cf_rd_data, rsp_hit=cf_rd_hit, rsp_err=0, then go to RESP.
  - Else the timer increments. When timer==TIMEOUT-1 without cf_rd_valid, register rsp_data=0, rsp_hit=0, rsp_err=1, then go to RESP.
  - If cf_rd_valid arrives in the same cycle as the timeout, the valid data wins.
- RESP:
  - rsp_valid[grant_id]=1 and data/flags are held stable.
  - When rsp_ready[grant_id]=1: clear rsp_valid and go to IDLE.
  - rsp_ready from non-winners is ignored.
- cf_rd_valid outside WAIT (stale response) is ignored and produces no response.
- Minimum turnaround is 4 cycles per request (IDLE, ISSUE, WAIT, RESP); only one read is outstanding at any time.
- A requester deasserting req_valid before it is granted is legal; it simply loses its turn. Once granted, the request cannot be cancelled.
- Round-robin is fair: with all requesters requesting continuously, grants occur in the order 0,1,2,3,0,...
- Timer width is $clog2(TIMEOUT+1); the timer saturates and does not wrap.
- Reset asserted mid-operation returns the FSM to IDLE immediately and clears all outputs; an in-flight cf_rd_valid after reset is ignored.

Decomposition:
- Shared package cache_fifo_pkg holds:
  - state enum arb_state_t (IDLE, ISSUE, WAIT, RESP)
  - default DATA_WIDTH/TAG_WIDTH constants, shared with cache_fifo
  - helper function clog2_min1 (returns at least 1, for NUM_REQ index width)
- Sub-module rr_arbiter(NUM_REQ) holds:
  - inputs: request vector, rr_ptr, enable
  - outputs: one-hot grant, binary winner index
  - it is combinational; rr_ptr is owned by the top-level FSM

Test Plan:
- Single request: req_valid=0001, tag=0x3C; cf returns data=0xDEADBEEF, hit=1 one cycle after rd_en. Expect cf_rd_en pulse with cf_rd_tag=0x3C, then rsp_valid=0001, rsp_data=0xDEADBEEF, rsp_hit=1, rsp_err=0.
- Round-robin fairness: req_valid=1111 held, rsp_ready=1111 tied high for 8 transactions. Expect grant_id sequence 0,1,2,3,0,1,2,3, exactly one cf_rd_en per 4 cycles, and req_ready always one-hot.
- Empty gating: cf_empty=1 with req_valid=0010 for 10 cycles. Expect no req_ready and no cf_rd_en. After cf_empty falls, expect a grant to requester 1 within 1 cycle.
- Timeout: TIMEOUT=15 and cf_rd_valid never asserted. Expect entry to RESP 15 cycles after entering WAIT, with rsp_err=1, rsp_data=0, rsp_hit=0. A later stale cf_rd_valid is ignored.
- Response backpressure: rsp_ready[2]=0 for 6 cycles while req_valid=1011. Expect rsp_valid=0100 and data stable, no new grant and busy=1. After rsp_ready[2]=1, the next grant goes to requester 3.
- Reset mid-WAIT: assert rst_n=0 during WAIT, release, then drive cf_rd_valid=1. Expect all outputs 0, state IDLE, no rsp_valid, and rr_ptr=0 so the next grant from req_valid=1111 goes to requester 0.
